// File: rtl/lbp_scan_sequencer_pkg.sv
// Shared definitions for the LBP ring scan sequencer: scan states and default
// ring size / phase lengths.
package lbp_scan_sequencer_pkg;

  localparam int N_PIX_DEF = 12;
  localparam int T_RST_DEF = 4;
  localparam int T_SH_DEF  = 4;
  localparam int T_CMP_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_GAP1,
    ST_SAMP,
    ST_GAP2,
    ST_CMP,
    ST_LATCH,
    ST_DONE
  } state_t;

  // Sizes the shared phase counter so it can hold the longest phase.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lbp_scan_sequencer_if.sv
// Control/status bundle between the scan sequencer (master) and the register
// interface plus analog switch controls (slave).
interface lbp_scan_sequencer_if #(
  parameter int N_PIX = 12
);
  logic             start_i;
  logic             abort_i;
  logic             cmp_i;
  logic             sh_rst_o;
  logic             sh_o;
  logic             sw1_o;
  logic             sh_cmp_o;
  logic             sw2_o;
  logic [N_PIX-1:0] pd_a_o;
  logic [N_PIX-1:0] pd_b_o;
  logic             busy_o;
  logic             done_o;
  logic [N_PIX-1:0] code_o;

  modport master (
    input  start_i, abort_i, cmp_i,
    output sh_rst_o, sh_o, sw1_o, sh_cmp_o, sw2_o,
    output pd_a_o, pd_b_o, busy_o, done_o, code_o
  );

  modport slave (
    output start_i, abort_i, cmp_i,
    input  sh_rst_o, sh_o, sw1_o, sh_cmp_o, sw2_o,
    input  pd_a_o, pd_b_o, busy_o, done_o, code_o
  );
endinterface

// File: rtl/lbp_scan_sequencer_sync2.sv
// Two-flop synchroniser bringing the asynchronous comparator decision into the
// scan clock domain.
module lbp_scan_sequencer_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lbp_scan_sequencer.sv
// Walks the photodiode ring once per start, sequencing reset/sample/compare
// switches for each pixel pair and collecting the comparator bits into a code.
module lbp_scan_sequencer
  import lbp_scan_sequencer_pkg::*;
#(
  parameter int N_PIX = N_PIX_DEF,
  parameter int T_RST = T_RST_DEF,
  parameter int T_SH  = T_SH_DEF,
  parameter int T_CMP = T_CMP_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  lbp_scan_sequencer_if.master bus
);

  localparam int T_MAX = maxOf3(T_RST, T_SH, T_CMP);
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int IDX_W = $clog2(N_PIX);

  state_t             r_state;
  logic [CNT_W-1:0]   r_phaseCnt;
  logic [IDX_W-1:0]   r_pixIdx;
  logic [N_PIX-1:0]   r_pdA;
  logic [N_PIX-1:0]   r_shadow;
  logic [N_PIX-1:0]   r_code;
  logic               r_shRst;
  logic               r_samp;
  logic               r_cmpPh;
  logic               r_busy;
  logic               r_done;
  logic               w_cmpSync;
  logic [N_PIX-1:0]   w_pdB;

  lbp_scan_sequencer_sync2 u_sync2 (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_d   (bus.cmp_i),
    .o_q   (w_cmpSync)
  );

  // Neighbour select is a pure rotation of the current-pixel register, so it
  // is glitch-free and wraps pixel N_PIX-1 onto pixel 0 for free.
  assign w_pdB = {r_pdA[N_PIX-2:0], r_pdA[N_PIX-1]};

  // Outputs are registered alongside the state so every switch changes on
  // the same edge as the phase it belongs to.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_phaseCnt <= '0;
      r_pixIdx   <= '0;
      r_pdA      <= '0;
      r_shadow   <= '0;
      r_code     <= '0;
      r_shRst    <= 1'b0;
      r_samp     <= 1'b0;
      r_cmpPh    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (bus.abort_i && (r_state != ST_IDLE)) begin
      r_state    <= ST_IDLE;
      r_phaseCnt <= '0;
      r_pixIdx   <= '0;
      r_pdA      <= '0;
      r_shRst    <= 1'b0;
      r_samp     <= 1'b0;
      r_cmpPh    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i && !bus.abort_i) begin
            r_state    <= ST_RST;
            r_phaseCnt <= CNT_W'(T_RST - 1);
            r_pixIdx   <= '0;
            r_pdA      <= N_PIX'(1);
            r_shRst    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_RST: begin
          if (r_phaseCnt == '0) begin
            r_state <= ST_GAP1;
            r_shRst <= 1'b0;
          end else begin
            r_phaseCnt <= r_phaseCnt - CNT_W'(1);
          end
        end
        ST_GAP1: begin
          r_state    <= ST_SAMP;
          r_phaseCnt <= CNT_W'(T_SH - 1);
          r_samp     <= 1'b1;
        end
        ST_SAMP: begin
          if (r_phaseCnt == '0) begin
            r_state <= ST_GAP2;
            r_samp  <= 1'b0;
          end else begin
            r_phaseCnt <= r_phaseCnt - CNT_W'(1);
          end
        end
        ST_GAP2: begin
          r_state    <= ST_CMP;
          r_phaseCnt <= CNT_W'(T_CMP - 1);
          r_cmpPh    <= 1'b1;
        end
        ST_CMP: begin
          if (r_phaseCnt == '0) begin
            r_state            <= ST_LATCH;
            r_cmpPh            <= 1'b0;
            r_shadow[r_pixIdx] <= w_cmpSync;
          end else begin
            r_phaseCnt <= r_phaseCnt - CNT_W'(1);
          end
        end
        ST_LATCH: begin
          if (r_pixIdx == IDX_W'(N_PIX - 1)) begin
            r_state <= ST_DONE;
            r_pdA   <= '0;
            r_code  <= r_shadow;
            r_done  <= 1'b1;
          end else begin
            r_state    <= ST_RST;
            r_phaseCnt <= CNT_W'(T_RST - 1);
            r_pixIdx   <= r_pixIdx + IDX_W'(1);
            r_pdA      <= w_pdB;
            r_shRst    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sh_rst_o = r_shRst;
  assign bus.sh_o     = r_samp;
  assign bus.sw1_o    = r_samp;
  assign bus.sh_cmp_o = r_cmpPh;
  assign bus.sw2_o    = r_cmpPh;
  assign bus.pd_a_o   = r_pdA;
  assign bus.pd_b_o   = w_pdB;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.code_o   = r_code;

endmodule

// File: tb/tb_lbp_scan_sequencer.sv
// Self-checking bench for lbp_scan_sequencer: every cycle of each scan is
// compared against a cycle-number model of the per-pixel phase schedule.
module tb_lbp_scan_sequencer;

  localparam int NP       = 12;
  localparam int PIX_LEN  = 15;
  localparam int DONE_CYC = NP * PIX_LEN + 1;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  logic [NP-1:0] expCode = '0;

  lbp_scan_sequencer_if #(.N_PIX(NP)) bus ();

  lbp_scan_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic start, input logic abort, input logic cmp);
    bus.start_i = start;
    bus.abort_i = abort;
    bus.cmp_i   = cmp;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string where, input logic eRst, input logic eSamp,
                            input logic eCmp, input logic [NP-1:0] ePdA,
                            input logic [NP-1:0] ePdB, input logic eBusy,
                            input logic eDone, input logic [NP-1:0] eCode);
    checkOutput({where, " sh_rst"}, 32'(bus.sh_rst_o), 32'(eRst));
    checkOutput({where, " sh"},     32'(bus.sh_o),     32'(eSamp));
    checkOutput({where, " sw1"},    32'(bus.sw1_o),    32'(eSamp));
    checkOutput({where, " sh_cmp"}, 32'(bus.sh_cmp_o), 32'(eCmp));
    checkOutput({where, " sw2"},    32'(bus.sw2_o),    32'(eCmp));
    checkOutput({where, " pd_a"},   32'(bus.pd_a_o),   32'(ePdA));
    checkOutput({where, " pd_b"},   32'(bus.pd_b_o),   32'(ePdB));
    checkOutput({where, " busy"},   32'(bus.busy_o),   32'(eBusy));
    checkOutput({where, " done"},   32'(bus.done_o),   32'(eDone));
    checkOutput({where, " code"},   32'(bus.code_o),   32'(eCode));
  endtask

  // fill: value of cmp_i outside compare phases (0, 1, or 2 = random noise).
  // abortAt/restartAt/rstAt: scan cycle for that event, 0 = never.
  task automatic runScan(input logic [NP-1:0] pattern, input int fill,
                         input int abortAt, input int restartAt, input int rstAt);
    logic [NP-1:0] oldCode;
    logic [NP-1:0] ePdA;
    logic [NP-1:0] ePdB;
    logic          cmpVal;
    logic          outside;
    int            lastCyc;
    int            k;
    int            p;
    int            off;
    string         where;
    oldCode = expCode;
    lastCyc = (abortAt > 0) ? abortAt + 4 : DONE_CYC + 2;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= lastCyc; c++) begin
      @(negedge clk);
      where = $sformatf("c%0d", c);
      k   = c - 1;
      p   = k / PIX_LEN;
      off = k % PIX_LEN;
      if (abortAt > 0 && c > abortAt) begin
        checkCycle(where, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, oldCode);
      end else if (c < DONE_CYC) begin
        ePdA = NP'(1) << p;
        ePdB = NP'(1) << ((p + 1) % NP);
        checkCycle(where, off < 4, off >= 5 && off <= 8, off >= 10 && off <= 13,
                   ePdA, ePdB, 1'b1, 1'b0, oldCode);
      end else if (c == DONE_CYC) begin
        checkCycle(where, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, pattern);
      end else begin
        checkCycle(where, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, pattern);
      end
      if (rstAt > 0 && c == rstAt) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkCycle({where, " async-rst"}, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        expCode = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCycle({where, " post-rst"}, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        return;
      end
      outside = (fill == 2) ? 1'($urandom_range(0, 1)) : 1'(fill);
      cmpVal  = (c < DONE_CYC && off >= 10 && off <= 13) ? pattern[p] : outside;
      applyStimulus(c == restartAt || c == abortAt, c == abortAt, cmpVal);
    end
    if (abortAt == 0) expCode = pattern;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NP-1:0] pat;
    $display("[TB] lbp_scan_sequencer bench starting");
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #12;
    checkCycle("reset", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkCycle("idle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

    $display("[TB] scan with comparator held high");
    runScan(12'hFFF, 1, 0, 0, 0);
    $display("[TB] scan with odd pixels high");
    runScan(12'hAAA, 0, 0, 0, 0);
    $display("[TB] scan yielding 0x0F0 with noise outside compare");
    runScan(12'h0F0, 2, 0, 0, 0);

    $display("[TB] abort at cycle 50 with simultaneous start");
    pat = 12'($urandom);
    runScan(pat, 2, 50, 0, 0);
    @(negedge clk);
    checkOutput("abort code kept", 32'(bus.code_o), 32'(12'h0F0));

    $display("[TB] start pulsed again at cycle 30");
    pat = 12'($urandom);
    runScan(pat, 2, 0, 30, 0);

    $display("[TB] reset during sample phase of pixel 3");
    pat = 12'($urandom) | 12'h001;
    runScan(pat, 2, 0, 0, 52);
    checkOutput("reset clears code", 32'(bus.code_o), 32'(12'h000));

    $display("[TB] full scans after reset");
    for (int n = 0; n < 2; n++) begin
      pat = 12'($urandom);
      runScan(pat, 2, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
